// File: rtl/quad_mux_arbiter.sv
// Two-requester arbiter steering one of two data words onto a shared path.
// Round-robin on contention, with a hold limit so a busy owner cannot starve the other side.
module quad_mux_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             grant0,
  output logic             grant1,
  output logic             sel,
  output logic             en,
  output logic [WIDTH-1:0] y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  state_t     state_nxt;
  logic       last;
  logic [7:0] hold_cnt;
  logic       hold_done;
  logic       grant_entry;

  assign hold_done   = (hold_cnt == HOLD_LAST);
  assign grant_entry = (state_nxt != IDLE) && (state_nxt != state);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last ? G0 : G1;
        else if (req0)     state_nxt = G0;
        else if (req1)     state_nxt = G1;
        else               state_nxt = IDLE;
      end
      G0: begin
        if (!req0)                 state_nxt = req1 ? G1 : IDLE;
        else if (req1 && hold_done) state_nxt = G1;
        else                       state_nxt = G0;
      end
      G1: begin
        if (!req1)                 state_nxt = req0 ? G0 : IDLE;
        else if (req0 && hold_done) state_nxt = G0;
        else                       state_nxt = G1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last resets to 1 so requester 0 wins the first contended arbitration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (grant_entry) begin
        hold_cnt <= 8'd0;
        last     <= (state_nxt == G1);
      end else if (state != IDLE && !hold_done) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

  assign grant0 = (state == G0);
  assign grant1 = (state == G1);
  assign sel    = (state == G1);
  assign en     = (state != IDLE);
  assign y      = en ? (sel ? b : a) : '0;

endmodule

// File: tb/tb_quad_mux_arbiter.sv
// Bench for quad_mux_arbiter: directed scenarios plus a random run, checked against
// a reference arbiter whose predicted outputs go through a scoreboard queue.
module tb_quad_mux_arbiter;

  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] a, b;
  logic             grant0, grant1, sel, en;
  logic [WIDTH-1:0] y;

  int total = 0;
  int bad   = 0;

  // expected packet: {grant0, grant1, sel, en, y}
  typedef logic [WIDTH+3:0] exp_t;
  exp_t sb_q[$];

  // reference model: 0 = idle, 1 = requester 0 owns, 2 = requester 1 owns
  int m_owner;
  int m_last;
  int m_hold;
  int w0, w1;

  quad_mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .a(a), .b(b),
    .grant0(grant0), .grant1(grant1), .sel(sel), .en(en), .y(y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_last  = 1;
    m_hold  = 0;
    w0 = 0;
    w1 = 0;
  endtask

  // predict the outputs after the next edge for the given inputs and queue them
  task automatic model_push(input logic r0, input logic r1,
                            input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    int nxt;
    exp_t e;
    nxt = m_owner;
    if (m_owner == 0) begin
      if (r0 && r1) nxt = (m_last == 1) ? 1 : 2;
      else if (r0)  nxt = 1;
      else if (r1)  nxt = 2;
    end else if (m_owner == 1) begin
      if (!r0) nxt = r1 ? 2 : 0;
      else if (r1 && m_hold == MAX_HOLD - 1) nxt = 2;
    end else begin
      if (!r1) nxt = r0 ? 1 : 0;
      else if (r0 && m_hold == MAX_HOLD - 1) nxt = 1;
    end
    if (nxt != 0 && nxt != m_owner) begin
      m_hold = 0;
      m_last = nxt - 1;
    end else if (m_owner != 0 && m_hold < MAX_HOLD - 1) begin
      m_hold++;
    end
    m_owner = nxt;
    e = {(nxt == 1), (nxt == 2), (nxt == 2), (nxt != 0),
         (nxt == 1) ? av : ((nxt == 2) ? bv : {WIDTH{1'b0}})};
    sb_q.push_back(e);
  endtask

  // drive one cycle of stimulus, then compare the DUT against the scoreboard head
  task automatic cycle(input logic r0, input logic r1,
                       input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    exp_t e;
    req0 = r0;
    req1 = r1;
    a    = av;
    b    = bv;
    model_push(r0, r1, av, bv);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 8'd1, 8'd0);
    end else begin
      e = sb_q.pop_front();
      chk("grant0", {7'd0, grant0}, {7'd0, e[WIDTH+3]});
      chk("grant1", {7'd0, grant1}, {7'd0, e[WIDTH+2]});
      chk("sel",    {7'd0, sel},    {7'd0, e[WIDTH+1]});
      chk("en",     {7'd0, en},     {7'd0, e[WIDTH]});
      chk("y",      8'(y),          8'(e[WIDTH-1:0]));
    end
    chk("mutex", {7'd0, grant0 & grant1}, 8'd0);
    w0 = (r0 && !grant0) ? w0 + 1 : 0;
    w1 = (r1 && !grant1) ? w1 + 1 : 0;
    chk("wait0_bound", {7'd0, (w0 > MAX_HOLD + 1)}, 8'd0);
    chk("wait1_bound", {7'd0, (w1 > MAX_HOLD + 1)}, 8'd0);
  endtask

  initial begin
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    a    = 4'hC;
    b    = 4'h6;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant0", {7'd0, grant0}, 8'd0);
    chk("rst_grant1", {7'd0, grant1}, 8'd0);
    chk("rst_sel",    {7'd0, sel},    8'd0);
    chk("rst_en",     {7'd0, en},     8'd0);
    chk("rst_y",      8'(y),          8'd0);
    #4;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // both requesting from reset: requester 0 first, preempted after MAX_HOLD cycles
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b1, 1'b1, 4'h5, 4'hA);
      if (i == 1) begin
        chk("first_grant0", {7'd0, grant0}, 8'd1);
        chk("first_y",      8'(y),          8'h05);
      end
      if (i == MAX_HOLD) chk("last_g0_cycle", {7'd0, grant0}, 8'd1);
      if (i == MAX_HOLD + 1) begin
        chk("preempt_grant1", {7'd0, grant1}, 8'd1);
        chk("preempt_y",      8'(y),          8'h0A);
      end
    end
    cycle(1'b0, 1'b0, 4'h5, 4'hA);
    chk("idle_y", 8'(y), 8'd0);

    // sole requester holds indefinitely
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 4'h1, 4'h3);
      chk("hold_grant1", {7'd0, grant1}, 8'd1);
    end
    chk("hold_y", 8'(y), 8'h03);
    cycle(1'b0, 1'b0, 4'h1, 4'h3);

    // owner 0 drops while 1 waits: direct handover, en never low
    repeat (3) cycle(1'b1, 1'b0, 4'h7, 4'h9);
    chk("pre_hand_en", {7'd0, en}, 8'd1);
    cycle(1'b0, 1'b1, 4'h7, 4'h9);
    chk("hand_grant1", {7'd0, grant1}, 8'd1);
    chk("hand_en",     {7'd0, en},     8'd1);
    chk("hand_y",      8'(y),          8'h09);

    // hold_cnt reaches 3 in G1, then asynchronous reset between edges
    repeat (3) cycle(1'b1, 1'b1, 4'h7, 4'h9);
    chk("pre_rst_grant1", {7'd0, grant1}, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_grant1", {7'd0, grant1}, 8'd0);
    chk("async_en",     {7'd0, en},     8'd0);
    chk("async_y",      8'(y),          8'd0);
    sb_q.delete();
    model_reset();
    #1;
    rst = 1'b0;
    cycle(1'b1, 1'b1, 4'h7, 4'h9);
    chk("post_rst_grant0", {7'd0, grant0}, 8'd1);

    // single-cycle pulse from idle
    repeat (2) cycle(1'b0, 1'b0, 4'hE, 4'h2);
    cycle(1'b1, 1'b0, 4'hE, 4'h2);
    chk("pulse_grant0", {7'd0, grant0}, 8'd1);
    cycle(1'b0, 1'b0, 4'hE, 4'h2);
    chk("pulse_idle_en", {7'd0, en}, 8'd0);
    chk("pulse_idle_y",  8'(y),      8'd0);

    // random requests
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
